// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg
// Core-wide register-file constants and types, shared with decode and the
// hazard unit.
//   DATA_W_DEF  : default register width in bits
//   ADDR_W_DEF  : default register address width (depth = 2**ADDR_W_DEF)
//   reg_addr_t  : register address at default width
//   data_word_t : register data word at default width
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] data_word_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard
// One pending bit per register, tracking destinations reserved by decode
// and not yet released by writeback.
// Ports:
//   clk          : core clock, rising edge
//   rst          : asynchronous active-low reset, clears all pending bits
//   i_rsv_en     : set pending[i_rsv_addr] at the next edge
//   i_rsv_addr   : register to reserve
//   i_rel_en     : clear pending[i_rel_addr] at the next edge
//   i_rel_addr   : register to release
//   o_pend       : registered pending vector
//   o_busy_any   : OR of the registered pending bits
module regfile_sb_scoreboard #(
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rsv_en,
  input  logic [ADDR_W-1:0]      i_rsv_addr,
  input  logic                   i_rel_en,
  input  logic [ADDR_W-1:0]      i_rel_addr,
  output logic [(1<<ADDR_W)-1:0] o_pend,
  output logic                   o_busy_any
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;

  // Reserve is applied after release so a same-cycle hand-over to a new
  // owner leaves the bit set.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_rel_en) w_pend_nxt[i_rel_addr] = 1'b0;
    if (i_rsv_en) w_pend_nxt[i_rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pend <= '0;
    else      r_pend <= w_pend_nxt;
  end

  assign o_pend     = r_pend;
  assign o_busy_any = |r_pend;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Parametrised register file with write-first bypass and a pending-write
// scoreboard. Sits between decode (read/reserve) and writeback
// (write/release).
// Build option: define REGFILE_ZERO_REG_EN to make register 0 a hard-wired
// zero (writes, reserves and releases to address 0 are dropped).
// Ports:
//   clk      : core clock, rising edge
//   rst      : asynchronous active-low reset
//   rd_addr  : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  : packed combinational read data, port k at [k*DATA_W +: DATA_W]
//   rd_rdy   : per-port ready, addressed register has no pending write
//   wr_en    : writeback strobe
//   wr_addr  : writeback destination
//   wr_data  : writeback value
//   wr_rel   : writeback also releases the pending bit of wr_addr
//   rsv_en   : decode reserves a destination
//   rsv_addr : register to mark pending
//   busy_any : any register pending
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_rdy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_rel,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     busy_any
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_pend;
  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic              w_rel_ok;

`ifdef REGFILE_ZERO_REG_EN
  // Register 0 is never written, so it keeps its reset value of zero and
  // its pending bit can never be set.
  assign w_wr_ok  = wr_en  && (wr_addr  != '0);
  assign w_rsv_ok = rsv_en && (rsv_addr != '0);
`else
  assign w_wr_ok  = wr_en;
  assign w_rsv_ok = rsv_en;
`endif

  assign w_rel_ok = w_wr_ok && wr_rel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  regfile_sb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_rsv_en   (w_rsv_ok),
    .i_rsv_addr (rsv_addr),
    .i_rel_en   (w_rel_ok),
    .i_rel_addr (wr_addr),
    .o_pend     (w_pend),
    .o_busy_any (busy_any)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;

    assign w_ra  = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_hit = w_wr_ok && (w_ra == wr_addr);

    assign rd_data[k*DATA_W +: DATA_W] = w_hit ? wr_data : r_mem[w_ra];
    // A releasing write makes the bypassed value consumable this cycle.
    assign rd_rdy[k] = !w_pend[w_ra] || (w_hit && wr_rel);
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int NR    = 2;
  localparam int DEPTH = 16;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_rdy;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             wr_rel = 1'b0;
  logic             rsv_en = 1'b0;
  logic [AW-1:0]    rsv_addr = '0;
  logic             busy_any;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: architectural register contents and pending set.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_pend [DEPTH];

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_rdy   (rd_rdy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_rel   (wr_rel),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_any (busy_any)
  );

  always #5 clk = ~clk;

  function automatic bit is_zreg(input logic [AW-1:0] a);
    return ZERO && (a == '0);
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (is_zreg(a)) return '0;
    if (wr_en && (a == wr_addr)) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_rdy(input logic [AW-1:0] a);
    if (is_zreg(a)) return 1'b1;
    if (wr_en && wr_rel && (a == wr_addr)) return 1'b1;
    return !m_pend[a];
  endfunction

  function automatic logic exp_busy();
    for (int i = 0; i < DEPTH; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_rel = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Advance one rising edge and apply the architectural update rules.
  task automatic step();
    @(posedge clk);
    if (wr_en && !is_zreg(wr_addr)) begin
      m_mem[wr_addr] = wr_data;
      if (wr_rel) m_pend[wr_addr] = 1'b0;
    end
    if (rsv_en && !is_zreg(rsv_addr)) m_pend[rsv_addr] = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rsv_en = 1'b1; rsv_addr = 4'd5;
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (busy_any !== 1'b0) $display("FAIL reset_hold_busy: busy_any=%b exp=0", busy_any);
    else n_pass++;
    n_total++;
    idle();
    rst = 1'b1;
    model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(DEPTH - 1 - a));
      @(negedge clk);
      if (rd_data !== '0) $display("FAIL reset_data a=%0d: rd_data=%h exp=0", a, rd_data);
      else n_pass++;
      n_total++;
      if (rd_rdy !== 2'b11) $display("FAIL reset_rdy a=%0d: rd_rdy=%b exp=11", a, rd_rdy);
      else n_pass++;
      n_total++;
    end
    if (busy_any !== 1'b0) $display("FAIL reset_busy: busy_any=%b exp=0", busy_any);
    else n_pass++;
    n_total++;
    #1;
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h1450;
    set_rd(4'd15, 4'd7);
    @(negedge clk);
    if (rd_data[DW-1:0] !== 16'h1450) $display("FAIL bypass_pre: rd_data0=%h exp=1450", rd_data[DW-1:0]);
    else n_pass++;
    n_total++;
    if (rd_data[2*DW-1:DW] !== 16'h0000) $display("FAIL bypass_other: rd_data1=%h exp=0000", rd_data[2*DW-1:DW]);
    else n_pass++;
    n_total++;
    step();
    idle();
    set_rd(4'd15, 4'd15);
    @(negedge clk);
    if (rd_data !== {16'h1450, 16'h1450}) $display("FAIL bypass_post: rd_data=%h exp=14501450", rd_data);
    else n_pass++;
    n_total++;
    step();
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = 4'd3;
    set_rd(4'd3, 4'd4);
    @(negedge clk);
    if (rd_rdy !== 2'b11) $display("FAIL rsv_same_cycle_rdy: rd_rdy=%b exp=11", rd_rdy);
    else n_pass++;
    n_total++;
    step();
    idle();
    @(negedge clk);
    if (rd_rdy !== 2'b10) $display("FAIL rsv_rdy: rd_rdy=%b exp=10", rd_rdy);
    else n_pass++;
    n_total++;
    if (busy_any !== 1'b1) $display("FAIL rsv_busy: busy_any=%b exp=1", busy_any);
    else n_pass++;
    n_total++;
    wr_en = 1'b1; wr_rel = 1'b1; wr_addr = 4'd3; wr_data = 16'h2150;
    #1;
    if (rd_rdy !== 2'b11) $display("FAIL rel_rdy: rd_rdy=%b exp=11", rd_rdy);
    else n_pass++;
    n_total++;
    if (rd_data[DW-1:0] !== 16'h2150) $display("FAIL rel_data: rd_data0=%h exp=2150", rd_data[DW-1:0]);
    else n_pass++;
    n_total++;
    step();
    idle();
    @(negedge clk);
    if (busy_any !== 1'b0) $display("FAIL rel_busy: busy_any=%b exp=0", busy_any);
    else n_pass++;
    n_total++;
    // Releasing a register that is not pending has no effect.
    wr_en = 1'b1; wr_rel = 1'b1; wr_addr = 4'd8; wr_data = 16'h0808;
    step();
    idle();
    @(negedge clk);
    if (busy_any !== 1'b0) $display("FAIL rel_nonpending: busy_any=%b exp=0", busy_any);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_rsv_rel_same();
    idle();
    rsv_en = 1'b1; rsv_addr = 4'd9;
    step();
    // Second reserve of an already-pending register plus a release in the
    // same cycle: the new owner keeps it pending.
    rsv_en = 1'b1; rsv_addr = 4'd9;
    wr_en = 1'b1; wr_rel = 1'b1; wr_addr = 4'd9; wr_data = 16'h0909;
    set_rd(4'd9, 4'd1);
    @(negedge clk);
    if (rd_rdy !== 2'b11) $display("FAIL same_cycle_fwd_rdy: rd_rdy=%b exp=11", rd_rdy);
    else n_pass++;
    n_total++;
    step();
    idle();
    @(negedge clk);
    if (rd_rdy !== 2'b10) $display("FAIL same_cycle_rdy: rd_rdy=%b exp=10", rd_rdy);
    else n_pass++;
    n_total++;
    if (busy_any !== 1'b1) $display("FAIL same_cycle_busy: busy_any=%b exp=1", busy_any);
    else n_pass++;
    n_total++;
    if (rd_data[DW-1:0] !== 16'h0909) $display("FAIL same_cycle_data: rd_data0=%h exp=0909", rd_data[DW-1:0]);
    else n_pass++;
    n_total++;
    wr_en = 1'b1; wr_rel = 1'b1; wr_addr = 4'd9; wr_data = 16'h0990;
    step();
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    rsv_en = 1'b1; rsv_addr = 4'd3;
    step();
    rsv_en = 1'b1; rsv_addr = 4'd10;
    wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'h0512;
    step();
    idle();
    set_rd(4'd3, 4'd10);
    @(negedge clk);
    if (rd_data[2*DW-1:DW] !== 16'h0512) $display("FAIL async_pre_data: rd_data1=%h exp=0512", rd_data[2*DW-1:DW]);
    else n_pass++;
    n_total++;
    if (rd_rdy !== 2'b00) $display("FAIL async_pre_rdy: rd_rdy=%b exp=00", rd_rdy);
    else n_pass++;
    n_total++;
    #1;
    rst = 1'b0;
    #1;
    if (rd_data !== '0) $display("FAIL async_data: rd_data=%h exp=0", rd_data);
    else n_pass++;
    n_total++;
    if (rd_rdy !== 2'b11) $display("FAIL async_rdy: rd_rdy=%b exp=11", rd_rdy);
    else n_pass++;
    n_total++;
    if (busy_any !== 1'b0) $display("FAIL async_busy: busy_any=%b exp=0", busy_any);
    else n_pass++;
    n_total++;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] exp_d;
    logic          exp_r;
    idle();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hBEEF;
    rsv_en = 1'b1; rsv_addr = 4'd0;
    step();
    idle();
    set_rd(4'd0, 4'd0);
    exp_d = ZERO ? 16'h0000 : 16'hBEEF;
    exp_r = ZERO ? 1'b1 : 1'b0;
    @(negedge clk);
    if (rd_data !== {exp_d, exp_d}) $display("FAIL zero_data: rd_data=%h exp=%h%h", rd_data, exp_d, exp_d);
    else n_pass++;
    n_total++;
    if (rd_rdy !== {exp_r, exp_r}) $display("FAIL zero_rdy: rd_rdy=%b exp=%b%b", rd_rdy, exp_r, exp_r);
    else n_pass++;
    n_total++;
    if (busy_any !== !exp_r) $display("FAIL zero_busy: busy_any=%b exp=%b", busy_any, !exp_r);
    else n_pass++;
    n_total++;
    wr_en = 1'b1; wr_rel = 1'b1; wr_addr = 4'd0; wr_data = 16'h0000;
    step();
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_rel   = $urandom_range(0, 1) == 1;
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = DW'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, DEPTH - 1));
      set_rd(($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1)),
             AW'($urandom_range(0, DEPTH - 1)));
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        if (rd_data[k*DW +: DW] !== exp_data(a))
          $display("FAIL rand_data n=%0d port=%0d addr=%0d: rd_data=%h exp=%h", n, k, a, rd_data[k*DW +: DW], exp_data(a));
        else n_pass++;
        n_total++;
        if (rd_rdy[k] !== exp_rdy(a))
          $display("FAIL rand_rdy n=%0d port=%0d addr=%0d: rd_rdy=%b exp=%b", n, k, a, rd_rdy[k], exp_rdy(a));
        else n_pass++;
        n_total++;
      end
      if (busy_any !== exp_busy())
        $display("FAIL rand_busy n=%0d: busy_any=%b exp=%b", n, busy_any, exp_busy());
      else n_pass++;
      n_total++;
      step();
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bypass();
    test_scoreboard();
    test_rsv_rel_same();
    test_async_reset();
    test_zero_reg();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 16x16 two-read/one-write register file.
- Adds configurable data width, depth and read-port count.
- Adds write-through bypass so a same-cycle write is visible on the read ports.
- Adds a per-register pending scoreboard so the decode stage can stall on registers still owed by an in-flight instruction.
- Sits between decode (read/reserve) and writeback (write/release).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, combinational
rd_rdy  output  NUM_RD  per-port ready: addressed register has no pending write
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback value
wr_rel  input  1  writeback also clears the pending bit of wr_addr
rsv_en  input  1  decode reserves a destination
rsv_addr  input  ADDR_W  register to mark pending
busy_any  output  1  OR of all pending bits (pipeline drain check)

Behaviour:
- Reset: clk and rst as named above; rst asynchronous, active-low.
  - While rst=0: all registers = 0 and all pending bits = 0.
  - Consequently rd_data = 0, rd_rdy = all 1s, busy_any = 0.
  - Reset mid-operation discards all reservations immediately, without waiting for a clock edge.
- Write: on a rising clk edge with wr_en=1, reg[wr_addr] <= wr_data.
  - wr_rel is ignored when wr_en=0.
- Read: combinational, zero latency.
  - If wr_en=1 and rd_addr_k == wr_addr: rd_data_k = wr_data (write-first bypass).
  - Otherwise rd_data_k = reg[rd_addr_k].
  - Each port is independent; any number of ports may address the same register.
- Scoreboard: one pending bit per register, updated at the rising edge.
  - rsv_en=1 sets pending[rsv_addr].
  - wr_en=1 with wr_rel=1 clears pending[wr_addr].
  - Same register reserved and released in the same cycle: reserve wins, bit ends set (new owner).
  - Reserving an already-pending register: stays set; no counting, one outstanding writer per register is the core's rule.
  - Releasing a non-pending register: no effect.
- rd_rdy_k: equals !pending[rd_addr_k], except it is forced to 1 when wr_en & wr_rel & (wr_addr == rd_addr_k).
  - This lets the reader consume the bypassed value in the same cycle.
  - A same-cycle rsv_en does not lower rd_rdy until the next cycle.
- busy_any: OR of the registered pending bits only; no bypass term.
- Address wrap: addresses are full-range ADDR_W; there are no out-of-range cases.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 reads as 0 on every port and rd_rdy for address 0 is always 1.
  - Writes to address 0 are discarded; the bypass does not forward them.
  - rsv_en/wr_rel targeting address 0 are ignored, so pending[0] stays 0.
- Undefined: register 0 is an ordinary register, identical to the others.

Decomposition:
- Shared package (core-wide, reused by decode and hazard unit): constants DATA_W_DEF=16 and ADDR_W_DEF=4.
- Same package also holds a typedef for a register address and a typedef for a data word.
- Natural sub-module: regfile_scoreboard.
  - Contains the pending-bit vector, set/clear priority and busy_any.
  - Main block keeps the storage array, the bypass muxes and the rd_rdy combine.

Test Plan:
- Reset check: hold rst=0, then release; read all 16 addresses on both ports -> rd_data=0x0000, rd_rdy=2'b11, busy_any=0.
- Write/read with bypass: wr_en=1, wr_addr=15, wr_data=0x1450, rd_addr0=15 in the same cycle -> rd_data0=0x1450 before the edge, and again after the edge with wr_en=0.
- Scoreboard hazard:
  - rsv_en=1, rsv_addr=3 -> next cycle rd_rdy for address 3 = 0 and busy_any=1.
  - Then wr_en=1, wr_rel=1, wr_addr=3, wr_data=0x2150 -> same cycle rd_rdy=1 and rd_data=0x2150; next cycle busy_any=0.
- Simultaneous reserve and release on address 9 -> pending[9] remains 1; rd_rdy for 9 = 0 next cycle.
- Async reset mid-op: reserve regs 3 and 10, write 0x0512 to reg 10, pulse rst low between edges -> outputs clear immediately; rd_data=0 and rd_rdy all 1s.
- With REGFILE_ZERO_REG_EN: write 0xBEEF to address 0 and reserve address 0 -> rd_data for address 0 = 0x0000, rd_rdy=1, busy_any=0.
  - Without the macro, the same stimulus -> 0xBEEF read back and busy_any=1.
